// File: rtl/hash_seq_ctrl.sv
// Per-block hash state sequencer for the SHA-256 core: fetches H0..H7 from SRAM,
// launches the compression engine, then feeds the working variables forward and writes back.
module hash_seq_ctrl #(
    parameter int HASH_LENGTH = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int RD_BASE     = 0,
    parameter int WR_BASE     = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic                        mem_rd_en,
    input  logic [31:0]                 mem_rd_data,
    output logic                        mem_wr_en,
    output logic [31:0]                 mem_wr_data,
    output logic [32*HASH_LENGTH-1:0]   hash_vector,
    output logic                        compress_start,
    input  logic                        compress_done,
    input  logic [32*HASH_LENGTH-1:0]   working_vector,
    output logic                        busy,
    output logic                        done
);

    localparam int                    CNT_W     = $clog2(HASH_LENGTH);
    localparam int                    VEC_W     = 32 * HASH_LENGTH;
    localparam logic [CNT_W-1:0]      LAST_IDX  = CNT_W'(HASH_LENGTH - 1);
    localparam logic [ADDR_WIDTH-1:0] RD_BASE_A = ADDR_WIDTH'(RD_BASE);
    localparam logic [ADDR_WIDTH-1:0] WR_BASE_A = ADDR_WIDTH'(WR_BASE);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_COMPRESS = 3'd3,
        ST_WRITE    = 3'd4,
        ST_FINISH   = 3'd5
    } state_t;

    state_t                  state_r, state_next_s;
    logic [CNT_W-1:0]        counter_r, counter_next_s, capture_idx_s;
    logic [VEC_W-1:0]        hash_vector_r, hash_next_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_r, addr_next_s;
    logic                    mem_rd_en_r, rd_en_next_s;
    logic                    mem_wr_en_r, wr_en_next_s;
    logic [31:0]             mem_wr_data_r, wr_data_next_s;
    logic                    compress_start_r, busy_r, done_r;

    // Word-wise feed-forward: each 32-bit lane wraps on its own, no carry between lanes.
    function automatic logic [VEC_W-1:0] feed_forward(input logic [VEC_W-1:0] h,
                                                      input logic [VEC_W-1:0] w);
        logic [VEC_W-1:0] s;
        s = {VEC_W{1'b0}};
        for (int i = 0; i < HASH_LENGTH; i++) begin
            s[32*i +: 32] = h[32*i +: 32] + w[32*i +: 32];
        end
        return s;
    endfunction

    // Next-state, word counter and hash capture/update.
    always_comb begin
        state_next_s   = state_r;
        counter_next_s = counter_r;
        hash_next_s    = hash_vector_r;
        capture_idx_s  = counter_r - CNT_W'(1);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s   = ST_LOAD;
                    counter_next_s = {CNT_W{1'b0}};
                end else begin
                    state_next_s   = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Read data lags the strobe by one cycle, so capture the previous word.
                if (counter_r != {CNT_W{1'b0}}) begin
                    hash_next_s[32*capture_idx_s +: 32] = mem_rd_data;
                end else begin
                    hash_next_s = hash_vector_r;
                end
                if (counter_r == LAST_IDX) begin
                    state_next_s   = ST_DRAIN;
                    counter_next_s = {CNT_W{1'b0}};
                end else begin
                    counter_next_s = counter_r + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                hash_next_s[32*LAST_IDX +: 32] = mem_rd_data;
                state_next_s                   = ST_COMPRESS;
            end
            ST_COMPRESS: begin
                // A done coincident with our own launch pulse cannot belong to this block.
                if (compress_done && !compress_start_r) begin
                    hash_next_s    = feed_forward(hash_vector_r, working_vector);
                    state_next_s   = ST_WRITE;
                    counter_next_s = {CNT_W{1'b0}};
                end else begin
                    state_next_s   = ST_COMPRESS;
                end
            end
            ST_WRITE: begin
                if (counter_r == LAST_IDX) begin
                    state_next_s   = ST_FINISH;
                    counter_next_s = {CNT_W{1'b0}};
                end else begin
                    counter_next_s = counter_r + CNT_W'(1);
                end
            end
            ST_FINISH: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s   = ST_IDLE;
                counter_next_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so they can be registered.
    always_comb begin
        rd_en_next_s = (state_next_s == ST_LOAD);
        wr_en_next_s = (state_next_s == ST_WRITE);
        if (rd_en_next_s) begin
            addr_next_s = RD_BASE_A + ADDR_WIDTH'(counter_next_s);
        end else if (wr_en_next_s) begin
            addr_next_s = WR_BASE_A + ADDR_WIDTH'(counter_next_s);
        end else begin
            addr_next_s = {ADDR_WIDTH{1'b0}};
        end
        if (wr_en_next_s) begin
            wr_data_next_s = hash_next_s[32*counter_next_s +: 32];
        end else begin
            wr_data_next_s = 32'd0;
        end
    end

    // State, counter, hash and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            counter_r        <= {CNT_W{1'b0}};
            hash_vector_r    <= {VEC_W{1'b0}};
            mem_addr_r       <= {ADDR_WIDTH{1'b0}};
            mem_rd_en_r      <= 1'b0;
            mem_wr_en_r      <= 1'b0;
            mem_wr_data_r    <= 32'd0;
            compress_start_r <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            counter_r        <= counter_next_s;
            hash_vector_r    <= hash_next_s;
            mem_addr_r       <= addr_next_s;
            mem_rd_en_r      <= rd_en_next_s;
            mem_wr_en_r      <= wr_en_next_s;
            mem_wr_data_r    <= wr_data_next_s;
            compress_start_r <= (state_r == ST_DRAIN);
            busy_r           <= (state_next_s != ST_IDLE);
            done_r           <= (state_next_s == ST_FINISH);
        end
    end

    assign mem_addr       = mem_addr_r;
    assign mem_rd_en      = mem_rd_en_r;
    assign mem_wr_en      = mem_wr_en_r;
    assign mem_wr_data    = mem_wr_data_r;
    assign hash_vector    = hash_vector_r;
    assign compress_start = compress_start_r;
    assign busy           = busy_r;
    assign done           = done_r;

endmodule

// File: tb/tb_hash_seq_ctrl.sv
// Directed bench for hash_seq_ctrl: SRAM model, cycle-exact strobe checks and
// hand-computed feed-forward results.
module tb_hash_seq_ctrl;

    logic         clock;
    logic         reset;
    logic         start;
    logic [7:0]   mem_addr;
    logic         mem_rd_en;
    logic [31:0]  mem_rd_data;
    logic         mem_wr_en;
    logic [31:0]  mem_wr_data;
    logic [255:0] hash_vector;
    logic         compress_start;
    logic         compress_done;
    logic [255:0] working_vector;
    logic         busy;
    logic         done;

    logic [31:0]  sram [0:255];
    logic         bk_we;
    logic [7:0]   bk_addr;
    logic [31:0]  bk_data;
    int           done_cnt;
    int           n_checks;
    int           n_fail;

    localparam logic [255:0] IV     = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                       32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    localparam logic [255:0] WORK_A = {32'h00000080, 32'h00000040, 32'h00000020, 32'h00000010,
                                       32'h00000008, 32'h00000004, 32'h00000002, 32'h00000001};
    localparam logic [255:0] SUM_A  = {32'h5be0cd99, 32'h1f83d9eb, 32'h9b0568ac, 32'h510e528f,
                                       32'ha54ff542, 32'h3c6ef376, 32'hbb67ae87, 32'h6a09e668};
    localparam logic [255:0] H_B    = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                       32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h00000002};
    localparam logic [255:0] WORK_B = {224'd0, 32'hffffffff};
    localparam logic [255:0] SUM_B  = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                       32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h00000001};

    hash_seq_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_data    (mem_rd_data),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_data    (mem_wr_data),
        .hash_vector    (hash_vector),
        .compress_start (compress_start),
        .compress_done  (compress_done),
        .working_vector (working_vector),
        .busy           (busy),
        .done           (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM with one-cycle read latency, a backdoor preload port and a done-pulse counter.
    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= sram[mem_addr];
        if (mem_wr_en) sram[mem_addr] <= mem_wr_data;
        if (bk_we) sram[bk_addr] <= bk_data;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_value(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic backdoor_write(input logic [7:0] addr, input logic [31:0] data);
        bk_we   = 1'b1;
        bk_addr = addr;
        bk_data = data;
        @(negedge clock);
        bk_we   = 1'b0;
    endtask

    // Called at a negedge in IDLE; start is sampled at the next edge (edge 0).
    task automatic run_block(input string name, input logic [255:0] h_exp,
                             input logic [255:0] work, input logic [255:0] sum_exp,
                             input int gap, input bit spurious, input int abort_writes);
        bit aborted;
        aborted        = 1'b0;
        working_vector = work;
        start          = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_value({name, " rd_en"}, 256'(mem_rd_en), 256'(1'b1));
            check_value({name, " rd_addr"}, 256'(mem_addr), 256'(k));
            check_value({name, " ld_wr_en"}, 256'(mem_wr_en), 256'(1'b0));
            check_value({name, " ld_busy"}, 256'(busy), 256'(1'b1));
            compress_done = (spurious && k == 3);
            @(negedge clock);
        end
        compress_done = 1'b0;
        check_value({name, " drain_rd_en"}, 256'(mem_rd_en), 256'(1'b0));
        check_value({name, " drain_addr"}, 256'(mem_addr), 256'(1'b0));
        check_value({name, " drain_cstart"}, 256'(compress_start), 256'(1'b0));
        @(negedge clock);
        check_value({name, " cstart"}, 256'(compress_start), 256'(1'b1));
        check_value({name, " fetched"}, hash_vector, h_exp);
        for (int c = 10; c < 10 + gap; c++) begin
            if (c > 10) begin
                check_value({name, " cstart_once"}, 256'(compress_start), 256'(1'b0));
                check_value({name, " wait_wr_en"}, 256'(mem_wr_en), 256'(1'b0));
            end
            compress_done = (spurious && c == 10);
            start         = (spurious && c == 12);
            @(negedge clock);
        end
        start         = 1'b0;
        compress_done = 1'b1;
        @(negedge clock);
        compress_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!aborted) begin
                check_value({name, " wr_en"}, 256'(mem_wr_en), 256'(1'b1));
                check_value({name, " wr_rd_en"}, 256'(mem_rd_en), 256'(1'b0));
                check_value({name, " wr_addr"}, 256'(mem_addr), 256'(8 + k));
                check_value({name, " wr_data"}, 256'(mem_wr_data), 256'(sum_exp[32*k +: 32]));
                check_value({name, " wr_done"}, 256'(done), 256'(1'b0));
                if (k == abort_writes - 1) begin
                    reset = 1'b1;
                    @(negedge clock);
                    reset = 1'b0;
                    check_value({name, " rst_busy"}, 256'(busy), 256'(1'b0));
                    check_value({name, " rst_wr_en"}, 256'(mem_wr_en), 256'(1'b0));
                    check_value({name, " rst_addr"}, 256'(mem_addr), 256'(1'b0));
                    check_value({name, " rst_hash"}, hash_vector, 256'd0);
                    aborted = 1'b1;
                end else begin
                    @(negedge clock);
                end
            end
        end
        if (!aborted) begin
            check_value({name, " done"}, 256'(done), 256'(1'b1));
            check_value({name, " fin_wr_en"}, 256'(mem_wr_en), 256'(1'b0));
            check_value({name, " fin_busy"}, 256'(busy), 256'(1'b1));
            check_value({name, " sum"}, hash_vector, sum_exp);
            @(negedge clock);
            check_value({name, " done_once"}, 256'(done), 256'(1'b0));
            check_value({name, " idle_busy"}, 256'(busy), 256'(1'b0));
            check_value({name, " hold"}, hash_vector, sum_exp);
        end else begin
            repeat (12) @(negedge clock);
            check_value({name, " no_done"}, 256'(done), 256'(1'b0));
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        done_cnt       = 0;
        reset          = 1'b1;
        start          = 1'b0;
        compress_done  = 1'b0;
        working_vector = 256'd0;
        bk_we          = 1'b0;
        bk_addr        = 8'd0;
        bk_data        = 32'd0;
        @(negedge clock);
        for (int i = 0; i < 8; i++) backdoor_write(8'(i), IV[32*i +: 32]);

        check_value("reset busy", 256'(busy), 256'(1'b0));
        check_value("reset strobes", 256'({mem_rd_en, mem_wr_en, compress_start, done}), 256'(4'd0));
        check_value("reset addr", 256'(mem_addr), 256'(8'd0));
        check_value("reset wr_data", 256'(mem_wr_data), 256'(32'd0));
        check_value("reset hash", hash_vector, 256'd0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check_value("idle quiet", 256'({mem_rd_en, mem_wr_en, busy, done, compress_start}),
                        256'(5'd0));
        end

        run_block("A", IV, WORK_A, SUM_A, 5, 1'b1, 0);
        check_value("A one done", 256'(done_cnt), 256'(1));

        backdoor_write(8'd0, 32'h00000002);
        run_block("B", H_B, WORK_B, SUM_B, 1, 1'b0, 0);

        for (int i = 8; i < 16; i++) backdoor_write(8'(i), 32'hdeadbeef);
        run_block("C", H_B, WORK_B, SUM_B, 3, 1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            check_value("C partial wr", 256'(sram[8 + i]), 256'(SUM_B[32*i +: 32]));
        end
        for (int i = 3; i < 8; i++) begin
            check_value("C untouched", 256'(sram[8 + i]), 256'(32'hdeadbeef));
        end
        check_value("C done count", 256'(done_cnt), 256'(2));

        run_block("D", H_B, WORK_B, SUM_B, 3, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            check_value("D sram", 256'(sram[8 + i]), 256'(SUM_B[32*i +: 32]));
        end
        check_value("total done", 256'(done_cnt), 256'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
